// File: rtl/palette_ram_mp_pkg.sv
// palette_pkg: shared types and constants for the multi-read-port palette RAM.
//   state_t      : init sequencer state encoding (ST_INIT / ST_IDLE)
//   DEFAULT_PAL  : 16 default 12-bit RGB entries, zero-extended when written
//   be_merge()   : byte-enable merge of a new word over an old word
// Optional feature macro used by the RTL: PALETTE_CLEAR_EN.
package palette_pkg;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    localparam int PAL_N = 16;

    localparam logic [11:0] DEFAULT_PAL [0:PAL_N-1] = '{
        12'h000, 12'hFFF, 12'h800, 12'hAFE,
        12'hC4C, 12'h0C5, 12'h00A, 12'hEE7,
        12'hD85, 12'h640, 12'hF77, 12'h333,
        12'h777, 12'hAF6, 12'h08F, 12'hBBB
    };

    // The merge helper works on a fixed maximum width; callers zero-extend
    // their word and truncate the result, so DATA_W up to MAX_W is supported.
    localparam int MAX_W  = 64;
    localparam int MAX_BE = MAX_W / 8;

    // Byte b of the result comes from new_w when ben[b] is set, else old_w.
    function automatic logic [MAX_W-1:0] be_merge(
        input logic [MAX_W-1:0]  old_w,
        input logic [MAX_W-1:0]  new_w,
        input logic [MAX_BE-1:0] ben
    );
        logic [MAX_W-1:0] m;
        m = old_w;
        for (int b = 0; b < MAX_BE; b++) begin
            if (ben[b]) begin
                m[8*b +: 8] = new_w[8*b +: 8];
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/palette_ram_mp_if.sv
// palette_ram_mp_if: CPU write port and NUM_RD read channels of the palette RAM.
//   wr_valid_i/wr_ready_o : write handshake, wr_addr_i/wr_data_i/ben_i payload
//   rd_en_i/rd_addr_i     : per-channel read strobe and packed addresses
//   rd_data_o/rd_valid_o  : per-channel registered read data and valid pulse
//   init_busy_o           : init sequencer owns the array
//   init_state_o          : sequencer state, exported for observation
// Handshake: a write beat transfers on a clock edge where wr_valid_i and
// wr_ready_o are both high; the master holds the payload stable until then.
// Reads have no handshake: every strobe while not busy yields exactly one
// rd_valid_o pulse one cycle later.
interface palette_ram_mp_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int NUM_RD = 2
);
    logic                     wr_valid_i;
    logic                     wr_ready_o;
    logic [ADDR_W-1:0]        wr_addr_i;
    logic [DATA_W-1:0]        wr_data_i;
    logic [DATA_W/8-1:0]      ben_i;
    logic [NUM_RD-1:0]        rd_en_i;
    logic [NUM_RD*ADDR_W-1:0] rd_addr_i;
    logic [NUM_RD*DATA_W-1:0] rd_data_o;
    logic [NUM_RD-1:0]        rd_valid_o;
    logic                     init_busy_o;
    palette_pkg::state_t      init_state_o;

    modport master (
        output wr_valid_i, wr_addr_i, wr_data_i, ben_i, rd_en_i, rd_addr_i,
        input  wr_ready_o, rd_data_o, rd_valid_o, init_busy_o, init_state_o
    );

    modport slave (
        input  wr_valid_i, wr_addr_i, wr_data_i, ben_i, rd_en_i, rd_addr_i,
        output wr_ready_o, rd_data_o, rd_valid_o, init_busy_o, init_state_o
    );
endinterface

// File: rtl/palette_ram_mp_init_seq.sv
// palette_init_seq: walks the whole palette after reset (and after clear_i
// when PALETTE_CLEAR_EN is defined), producing one write per cycle.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clear        : (PALETTE_CLEAR_EN only) restart init from IDLE
//   o_busy         : sequencer owns the array (also its write enable)
//   o_addr, o_data : entry being written this cycle
//   o_state        : current FSM state
module palette_init_seq
    import palette_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
`ifdef PALETTE_CLEAR_EN
    input  logic              i_clear,
`endif
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data,
    output state_t            o_state
);

    state_t          r_state;
    state_t          w_state_next;
    // One spare MSB: it sets exactly when the last entry has been written,
    // so the low bits never alias back onto entry 0 while still in INIT.
    logic [ADDR_W:0] r_cnt;
    logic [ADDR_W:0] w_cnt_next;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_INIT: begin
                w_cnt_next = r_cnt + {{ADDR_W{1'b0}}, 1'b1};
                if (w_cnt_next[ADDR_W]) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
`ifdef PALETTE_CLEAR_EN
                if (i_clear) begin
                    w_state_next = ST_INIT;
                    w_cnt_next   = '0;
                end
`endif
            end
            default: begin
                w_state_next = ST_INIT;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign o_busy  = (r_state == ST_INIT);
    assign o_addr  = r_cnt[ADDR_W-1:0];
    assign o_state = r_state;

    // Only the first PAL_N entries carry a default colour; the rest are black.
    always_comb begin
        o_data = '0;
        if (r_cnt[ADDR_W:4] == '0) begin
            o_data = DATA_W'(DEFAULT_PAL[r_cnt[3:0]]);
        end
    end

endmodule

// File: rtl/palette_ram_mp.sv
// palette_ram_mp: palette RAM with one CPU write port and NUM_RD independent
// registered read channels, self-initialised with the default palette.
//   clk_i   : single clock for all ports
//   rst_n_i : asynchronous active-low reset (restarts the init sequence)
//   clear_i : (PALETTE_CLEAR_EN only) pulse in IDLE to re-run the init sequence
//   bus     : palette_ram_mp_if slave (write port, read channels, busy/state)
// Parameters: DATA_W (multiple of 8, <= 64), ADDR_W (>= 4), NUM_RD (1..4),
// BYPASS (1 = same-cycle write data forwarded to colliding reads).
// Optional feature macro: PALETTE_CLEAR_EN.
module palette_ram_mp
    import palette_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int NUM_RD = 2,
    parameter int BYPASS = 1
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
`ifdef PALETTE_CLEAR_EN
    input  logic           clear_i,
`endif
    palette_ram_mp_if.slave bus
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int BE_W  = DATA_W / 8;

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];

    logic              w_busy;
    logic [ADDR_W-1:0] w_init_addr;
    logic [DATA_W-1:0] w_init_data;
    state_t            w_state;
    logic              w_wr_fire;

    palette_init_seq #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_init_seq (
        .i_clk   (clk_i),
        .i_rst_n (rst_n_i),
`ifdef PALETTE_CLEAR_EN
        .i_clear (clear_i),
`endif
        .o_busy  (w_busy),
        .o_addr  (w_init_addr),
        .o_data  (w_init_data),
        .o_state (w_state)
    );

    assign bus.wr_ready_o   = ~w_busy;
    assign bus.init_busy_o  = w_busy;
    assign bus.init_state_o = w_state;
    assign w_wr_fire        = bus.wr_valid_i & ~w_busy;

    // Array write mux: the sequencer has the port while busy, otherwise the
    // CPU writes only its enabled bytes. Contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (w_busy) begin
            r_mem[w_init_addr] <= w_init_data;
        end else if (w_wr_fire) begin
            for (int b = 0; b < BE_W; b++) begin
                if (bus.ben_i[b]) begin
                    r_mem[bus.wr_addr_i][8*b +: 8] <= bus.wr_data_i[8*b +: 8];
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] w_old;
        logic [DATA_W-1:0] w_word;
        logic              w_hit;
        logic              w_take;
        logic [DATA_W-1:0] r_data;
        logic              r_valid;

        assign w_addr = bus.rd_addr_i[k*ADDR_W +: ADDR_W];
        assign w_old  = r_mem[w_addr];
        // The array read sees pre-edge contents, so without forwarding a
        // colliding read naturally returns the old value.
        assign w_hit  = (BYPASS != 0) && w_wr_fire && (bus.wr_addr_i == w_addr);
        assign w_word = w_hit ? DATA_W'(be_merge(MAX_W'(w_old),
                                                 MAX_W'(bus.wr_data_i),
                                                 MAX_BE'(bus.ben_i)))
                              : w_old;
        assign w_take = bus.rd_en_i[k] & ~w_busy;

        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                r_data  <= '0;
                r_valid <= 1'b0;
            end else begin
                r_valid <= w_take;
                if (w_take) begin
                    r_data <= w_word;
                end
            end
        end

        assign bus.rd_data_o[k*DATA_W +: DATA_W] = r_data;
        assign bus.rd_valid_o[k]                 = r_valid;
    end

endmodule

// File: tb/tb_palette_ram_mp.sv
// tb_palette_ram_mp: directed bench for palette_ram_mp. Two instances run in
// lockstep: dut_a (NUM_RD=4, BYPASS=1) and dut_b (NUM_RD=2, BYPASS=0), with
// dut_b's channels fed from channels 0..1 of dut_a's stimulus.
module tb_palette_ram_mp;
    import palette_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;
    int rv_cnt = 0;

    always #5 clk = ~clk;

    palette_ram_mp_if #(.DATA_W(16), .ADDR_W(8), .NUM_RD(4)) ifa ();
    palette_ram_mp_if #(.DATA_W(16), .ADDR_W(8), .NUM_RD(2)) ifb ();

    assign ifb.wr_valid_i = ifa.wr_valid_i;
    assign ifb.wr_addr_i  = ifa.wr_addr_i;
    assign ifb.wr_data_i  = ifa.wr_data_i;
    assign ifb.ben_i      = ifa.ben_i;
    assign ifb.rd_en_i    = ifa.rd_en_i[1:0];
    assign ifb.rd_addr_i  = ifa.rd_addr_i[15:0];

    palette_ram_mp #(.DATA_W(16), .ADDR_W(8), .NUM_RD(4), .BYPASS(1)) dut_a (
        .clk_i   (clk),
        .rst_n_i (rst_n),
`ifdef PALETTE_CLEAR_EN
        .clear_i (clear),
`endif
        .bus     (ifa)
    );

    palette_ram_mp #(.DATA_W(16), .ADDR_W(8), .NUM_RD(2), .BYPASS(0)) dut_b (
        .clk_i   (clk),
        .rst_n_i (rst_n),
`ifdef PALETTE_CLEAR_EN
        .clear_i (clear),
`endif
        .bus     (ifb)
    );

    typedef struct {
        string       name;
        logic [3:0]  en;
        logic [31:0] raddr;   // {ch3, ch2, ch1, ch0}
        logic        wr;
        logic [7:0]  waddr;
        logic [15:0] wdata;
        logic [1:0]  ben;
        logic [63:0] exp_a;   // {ch3, ch2, ch1, ch0}
        logic [3:0]  vld_a;
        logic [31:0] exp_b;   // {ch1, ch0}
        logic [1:0]  vld_b;
    } vec_t;

    vec_t vecs [0:10];

    // ---------------- clock / reset helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Counts busy samples (bounded); also tallies any handshake or read
    // valid seen while busy.
    task automatic wait_init(output int n);
        n = 0;
        while (ifa.init_busy_o && n < 1000) begin
            n++;
            if (ifa.wr_valid_i && ifa.wr_ready_o) hs_cnt++;
            if (|ifa.rd_valid_o || |ifb.rd_valid_o) rv_cnt++;
            cyc();
        end
    endtask

    task automatic idle_inputs();
        ifa.wr_valid_i = 1'b0;
        ifa.wr_addr_i  = '0;
        ifa.wr_data_i  = '0;
        ifa.ben_i      = '0;
        ifa.rd_en_i    = '0;
        ifa.rd_addr_i  = '0;
    endtask

    // ---------------- driver ----------------
    task automatic apply(input vec_t v);
        ifa.rd_en_i    = v.en;
        ifa.rd_addr_i  = v.raddr;
        ifa.wr_valid_i = v.wr;
        ifa.wr_addr_i  = v.waddr;
        ifa.wr_data_i  = v.wdata;
        ifa.ben_i      = v.ben;
        cyc();
        chk({v.name, "_data_a"},  ifa.rd_data_o,          v.exp_a);
        chk({v.name, "_valid_a"}, 64'(ifa.rd_valid_o),    64'(v.vld_a));
        chk({v.name, "_data_b"},  64'(ifb.rd_data_o),     64'(v.exp_b));
        chk({v.name, "_valid_b"}, 64'(ifb.rd_valid_o),    64'(v.vld_b));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n;

        vecs[0]  = '{"rd_init",   4'b1111, {8'd0, 8'd200, 8'd15, 8'd1}, 1'b0, 8'h00, 16'h0000, 2'b00,
                     {16'h0000, 16'h0000, 16'h0BBB, 16'h0FFF}, 4'b1111, {16'h0BBB, 16'h0FFF}, 2'b11};
        vecs[1]  = '{"hold",      4'b0000, {8'd0, 8'd200, 8'd15, 8'd1}, 1'b0, 8'h00, 16'h0000, 2'b00,
                     {16'h0000, 16'h0000, 16'h0BBB, 16'h0FFF}, 4'b0000, {16'h0BBB, 16'h0FFF}, 2'b00};
        vecs[2]  = '{"wr_lo",     4'b0000, 32'h0,                       1'b1, 8'h20, 16'h1234, 2'b01,
                     {16'h0000, 16'h0000, 16'h0BBB, 16'h0FFF}, 4'b0000, {16'h0BBB, 16'h0FFF}, 2'b00};
        vecs[3]  = '{"wr_hi",     4'b0000, 32'h0,                       1'b1, 8'h20, 16'hAB00, 2'b10,
                     {16'h0000, 16'h0000, 16'h0BBB, 16'h0FFF}, 4'b0000, {16'h0BBB, 16'h0FFF}, 2'b00};
        vecs[4]  = '{"rd_merge",  4'b1111, {8'h05, 8'h21, 8'h20, 8'h20}, 1'b0, 8'h00, 16'h0000, 2'b00,
                     {16'h00C5, 16'h0000, 16'hAB34, 16'hAB34}, 4'b1111, {16'hAB34, 16'hAB34}, 2'b11};
        vecs[5]  = '{"coll_full", 4'b0111, {8'h00, 8'h06, 8'h05, 8'h05}, 1'b1, 8'h05, 16'h0F0F, 2'b11,
                     {16'h00C5, 16'h000A, 16'h0F0F, 16'h0F0F}, 4'b0111, {16'h00C5, 16'h00C5}, 2'b11};
        vecs[6]  = '{"post_coll", 4'b0011, {8'h00, 8'h06, 8'h05, 8'h05}, 1'b0, 8'h00, 16'h0000, 2'b00,
                     {16'h00C5, 16'h000A, 16'h0F0F, 16'h0F0F}, 4'b0011, {16'h0F0F, 16'h0F0F}, 2'b11};
        vecs[7]  = '{"four_ch",   4'b1111, {8'd14, 8'd7, 8'd3, 8'd0},   1'b0, 8'h00, 16'h0000, 2'b00,
                     {16'h008F, 16'h0EE7, 16'h0AFE, 16'h0000}, 4'b1111, {16'h0AFE, 16'h0000}, 2'b11};
        vecs[8]  = '{"coll_part", 4'b0011, {8'd14, 8'd7, 8'd7, 8'd7},   1'b1, 8'h07, 16'h1234, 2'b01,
                     {16'h008F, 16'h0EE7, 16'h0E34, 16'h0E34}, 4'b0011, {16'h0EE7, 16'h0EE7}, 2'b11};
        vecs[9]  = '{"ben_zero",  4'b0011, {8'd14, 8'd7, 8'd7, 8'd3},   1'b1, 8'h03, 16'hFFFF, 2'b00,
                     {16'h008F, 16'h0EE7, 16'h0E34, 16'h0AFE}, 4'b0011, {16'h0E34, 16'h0AFE}, 2'b11};
        vecs[10] = '{"ben0_rb",   4'b0001, {8'd14, 8'd7, 8'd7, 8'd3},   1'b0, 8'h00, 16'h0000, 2'b00,
                     {16'h008F, 16'h0EE7, 16'h0E34, 16'h0AFE}, 4'b0001, {16'h0E34, 16'h0AFE}, 2'b01};

        // ---------------- reset ----------------
        idle_inputs();
        rst_n = 1'b0;
        cyc();
        cyc();
        chk("rst_busy",  64'(ifa.init_busy_o),  64'd1);
        chk("rst_ready", 64'(ifa.wr_ready_o),   64'd0);
        chk("rst_valid", 64'(ifa.rd_valid_o),   64'd0);
        chk("rst_data",  ifa.rd_data_o,         64'd0);
        chk("rst_state", 64'(ifa.init_state_o), 64'(ST_INIT));
        rst_n = 1'b1;

        // ---------------- init length ----------------
        wait_init(n);
        chk("init_len",    64'(n),                 64'd256);
        chk("init_ready",  64'(ifa.wr_ready_o),    64'd1);
        chk("init_state",  64'(ifa.init_state_o),  64'(ST_IDLE));
        chk("init_busy_b", 64'(ifb.init_busy_o),   64'd0);

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 11; i++) begin
            apply(vecs[i]);
        end
        idle_inputs();

        // ---------------- reset mid-operation ----------------
        rst_n = 1'b0;
        #1;
        chk("midop_data",  ifa.rd_data_o,        64'd0);
        chk("midop_busy",  64'(ifa.init_busy_o), 64'd1);
        chk("midop_ready", 64'(ifa.wr_ready_o),  64'd0);
        rst_n = 1'b1;

        // Write held pending and reads strobed all through INIT.
        hs_cnt = 0;
        rv_cnt = 0;
        ifa.wr_valid_i = 1'b1;
        ifa.wr_addr_i  = 8'h40;
        ifa.wr_data_i  = 16'h5A5A;
        ifa.ben_i      = 2'b11;
        ifa.rd_en_i    = 4'b1111;
        ifa.rd_addr_i  = 32'h0;
        for (int i = 0; i < 100; i++) begin
            if (ifa.wr_valid_i && ifa.wr_ready_o) hs_cnt++;
            if (|ifa.rd_valid_o || |ifb.rd_valid_o) rv_cnt++;
            cyc();
        end

        // ---------------- reset at init count 100 ----------------
        rst_n = 1'b0;
        #1;
        chk("midinit_busy",  64'(ifa.init_busy_o),  64'd1);
        chk("midinit_ready", 64'(ifa.wr_ready_o),   64'd0);
        chk("midinit_state", 64'(ifa.init_state_o), 64'(ST_INIT));
        rst_n = 1'b1;
        wait_init(n);
        chk("reinit_len",   64'(n),              64'd256);
        chk("init_no_hs",   64'(hs_cnt),         64'd0);
        chk("init_no_rv",   64'(rv_cnt),         64'd0);
        chk("last_busy_rv", 64'(ifa.rd_valid_o), 64'd0);
        ifa.rd_en_i = 4'b0000;
        cyc();                      // pending write handshakes here
        idle_inputs();
        ifa.rd_en_i   = 4'b0111;
        ifa.rd_addr_i = {8'h00, 8'h05, 8'h20, 8'h40};
        cyc();
        chk("stall_wr_a", ifa.rd_data_o[47:0],  {16'h00C5, 16'h0000, 16'h5A5A});
        chk("stall_wr_v", 64'(ifa.rd_valid_o),  64'(4'b0111));
        chk("stall_wr_b", 64'(ifb.rd_data_o),   64'({16'h0000, 16'h5A5A}));
        idle_inputs();

`ifdef PALETTE_CLEAR_EN
        // ---------------- clear re-runs init ----------------
        ifa.wr_valid_i = 1'b1;
        ifa.wr_addr_i  = 8'h01;
        ifa.wr_data_i  = 16'h0123;
        ifa.ben_i      = 2'b11;
        cyc();
        idle_inputs();
        ifa.rd_en_i   = 4'b0001;
        ifa.rd_addr_i = 32'h01;
        cyc();
        chk("pre_clear", 64'(ifa.rd_data_o[15:0]), 64'h0123);
        idle_inputs();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        chk("clear_busy", 64'(ifa.init_busy_o), 64'd1);
        n = 0;
        while (ifa.init_busy_o && n < 1000) begin
            clear = (n == 10);      // ignored while already in INIT
            n++;
            cyc();
        end
        clear = 1'b0;
        chk("clear_len", 64'(n), 64'd256);
        ifa.rd_en_i   = 4'b0001;
        ifa.rd_addr_i = 32'h01;
        cyc();
        chk("post_clear", 64'(ifa.rd_data_o[15:0]), 64'h0FFF);
        idle_inputs();
`endif

        cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/palette_ram_mp.md
Name: palette_ram_mp

Overview:
- Parametrised multi-read-port palette RAM for the video pipeline; successor to the single-read palette store.
- One shared clock for the CPU write port and NUM_RD independent read channels (layers, sprites, border).
- A built-in init sequencer rewrites the whole table with the default palette after reset.
- Write-to-read forwarding gives coherent same-cycle read/write results.

Parameters:
- DATA_W, 16, entry width in bits; must be a multiple of 8.
- ADDR_W, 8, address width; depth = 2**ADDR_W.
- NUM_RD, 2, number of read channels (1..4).
- BYPASS, 1, 1 = forward same-cycle writes to reads; 0 = read returns old data.

Ports:
- clk_i  in  1  single clock for all ports.
- rst_n_i  in  1  asynchronous, active-low reset.
- wr_valid_i  in  1  write request.
- wr_ready_o  out  1  write accepted when wr_valid_i && wr_ready_o.
- wr_addr_i  in  ADDR_W  write address.
- wr_data_i  in  DATA_W  write data.
- ben_i  in  DATA_W/8  byte enables; bit b covers bits [8b+7:8b].
- rd_en_i  in  NUM_RD  per-channel read strobe.
- rd_addr_i  in  NUM_RD*ADDR_W  channel k uses slice [k*ADDR_W +: ADDR_W].
- rd_data_o  out  NUM_RD*DATA_W  channel k read data, registered.
- rd_valid_o  out  NUM_RD  per-channel read data valid.
- init_busy_o  out  1  high while the init sequencer owns the array.

Behaviour:
- Reset values (async, rst_n_i low): rd_data_o=0, rd_valid_o=0, wr_ready_o=0, init_busy_o=1, FSM=INIT, init counter=0. Array contents are not reset.
- FSM states:
  - INIT: writes one entry per cycle. Entry i gets DEFAULT_PAL[i] for i<16 and 0 otherwise. Counter increments each cycle. After writing entry 2**ADDR_W-1 the FSM moves to IDLE, so INIT lasts exactly 2**ADDR_W cycles after reset release.
  - IDLE: wr_ready_o=1, init_busy_o=0.
- During INIT:
  - wr_ready_o=0, so CPU writes stall and are never dropped.
  - Reads are ignored: rd_valid_o stays 0.
- Write: on the accepted beat, each enabled byte is updated at the next clock edge. ben_i=0 with wr_valid_i=1 is accepted and writes nothing.
- Read:
  - Latency 1. rd_en_i[k] at edge N gives rd_data_o/rd_valid_o[k] valid after edge N.
  - rd_valid_o[k] is a one-cycle pulse per strobe.
  - When rd_en_i[k]=0, rd_data_o[k] holds its last value.
- Channel independence: all channels may read the same or different addresses in the same cycle with no arbitration and no stall.
- Same-cycle collision (accepted write and channel k reading the same address):
  - BYPASS=1: enabled bytes come from wr_data_i, disabled bytes from the array.
  - BYPASS=0: channel k returns the pre-write value.
- Address wrap: the init counter is ADDR_W+1 bits, and its MSB signals done. No aliasing is allowed when depth=2**ADDR_W.
- Reset mid-INIT or mid-operation: the FSM restarts INIT from entry 0. The in-flight write is lost, and the full table is reinitialised.

Optional Feature:
- Macro: PALETTE_CLEAR_EN.
- Defined:
  - Adds input port clear_i (1 bit).
  - A one-cycle pulse in IDLE re-enters INIT with counter=0 on the next edge.
  - A write accepted in the same cycle as clear_i completes first, then is overwritten by the sequence.
  - clear_i during INIT is ignored.
- Undefined: the port is absent, and INIT runs only after reset.

Decomposition:
- Package palette_pkg holds:
  - DEFAULT_PAL[0:15], 12-bit RGB values zero-extended: 000 FFF 800 AFE C4C 0C5 00A EE7 D85 640 F77 333 777 AF6 08F BBB.
  - FSM state encoding ST_INIT / ST_IDLE.
  - Helper function for byte-enable merge.
- Sub-module palette_init_seq: FSM, counter, init address/data generation, busy flag, and clear handling.
- Top level contains:
  - The array, written either by the sequencer or the CPU port through a mux.
  - NUM_RD generate-loop read registers.
  - Bypass logic.

Test Plan:
1. Reset release -> init_busy_o=1 for exactly 256 cycles, then wr_ready_o=1. Read ch0 addr 1 returns 16'h0FFF; addr 15 returns 16'h0BBB; addr 200 returns 16'h0000.
2. Write addr 0x20 data 16'h1234 ben=2'b01, then ben=2'b10 data 16'hAB00 -> read returns 16'hAB34 one cycle after rd_en.
3. BYPASS=1: same cycle write 0x05 data 16'h0F0F ben=2'b11 while ch0 and ch1 both read 0x05 -> both rd_data_o=16'h0F0F with rd_valid_o=2'b11. BYPASS=0 -> both return 16'h00C5.
4. NUM_RD=4, four distinct addresses 0,3,7,14 read in one cycle -> 16'h0000, 16'h0AFE, 16'h0EE7, 16'h008F, all valid next cycle.
5. wr_valid_i held high during INIT -> no handshake until busy drops. The write lands after init and reads back correctly.
6. rst_n_i asserted at init count 100 -> outputs zero immediately. After release, INIT runs a full 256 cycles. With PALETTE_CLEAR_EN, clear_i in IDLE after writing 0x01=16'h0123 -> addr 0x01 reads 16'h0FFF after 256 busy cycles.
